counter_share_ctrl: RTL and testbench
=====================================

// Module: counter_share_ctrl
// PURPOSE
//  Scheduler that shares one WIDTH-bit up-counter between NREQ requesters.
//  Each requester asks for a run of LEN ticks over valid/ready. A round-robin
//  pick grants one requester, then the block clears the counter, steps it LEN
//  times and reports completion with the owner id over valid/ready.
//  It sits between client agents and the single counter datapath.
// PARAMETERS
//  NREQ   4  number of requesters (2..16)
//  WIDTH  8  counter/length width in bits
//  IDW    $clog2(NREQ)  localparam, owner id width (not overridable)
// PORTS
//  clk         in   1           clock, all state on rising edge
//  rst         in   1           asynchronous reset, active-low (0 = reset)
//  req_valid   in   NREQ        bit i: requester i has a run request
//  req_len     in   NREQ*WIDTH  slice i = run length of requester i
//  req_ready   out  NREQ        one-hot grant/accept, only in IDLE
//  hold        in   1           1 = freeze counter in RUN (pause)
//  cnt_clr     out  1           1 = counter being cleared this cycle
//  cnt_en      out  1           1 = counter steps +1 this cycle
//  count       out  WIDTH       current counter value
//  busy        out  1           1 when state != IDLE
//  owner       out  IDW         id of current grantee (valid when busy)
//  done_valid  out  1           completion pending
//  done_id     out  IDW         id of finished requester (= owner)
//  done_ready  in   1           consumer accepts completion
// BEHAVIOUR
//  Reset: state=IDLE, count=0, owner=0, rr_ptr=0, len_q=0; all outputs 0.
//  FSM states IDLE, CLEAR, RUN, DONE (2-bit encoding, enum in package).
//  IDLE: g = first i with req_valid[i], scanning from rr_ptr upward (mod NREQ).
//   - If found: req_ready[g]=1 combinationally this cycle. Handshake completes.
//     Latch len_q=req_len[g] and owner=g, then go to CLEAR.
//   - No valid: stay in IDLE, req_ready=0. Never more than one req_ready bit set.
//  CLEAR: cnt_clr=1 and count<=0 (one cycle). Next state is RUN, or DONE if len_q==0.
//  RUN: cnt_en = !hold. When cnt_en, count<=count+1 (mod 2^WIDTH).
//   When cnt_en and count+1==len_q, go to DONE. The run therefore takes exactly
//   len_q enabled cycles and ends with count==len_q.
//   hold=1 freezes count and state; cnt_en=0.
//  DONE: done_valid=1, done_id=owner, count holds. On done_ready=1:
//   rr_ptr<=(owner+1) mod NREQ and state<=IDLE. done_valid is asserted only in DONE.
//  len_q=2^WIDTH-1 is legal. count never wraps within a run.
//  busy = (state!=IDLE). hold is ignored outside RUN.
//  req_valid drop in IDLE without ready: the request is not taken, no error.
//  rst low mid-run: immediate return to reset values. The run is lost and no done is issued.
// STRUCTURE
//  Package counter_share_pkg: state enum cs_state_e {CS_IDLE,CS_CLEAR,CS_RUN,
//   CS_DONE}, localparam CS_MAX_NREQ=16.
//  Sub-module counter_share_rr_pick (combinational): inputs req, ptr;
//   outputs onehot grant, gid, any. The top holds the FSM, counter, len_q, owner and rr_ptr.
// TESTING
//  1 Reset: rst=0 with random inputs -> all outputs 0. After release, state IDLE.
//  2 Single run: req_valid=4'b0010, len=3. Expect req_ready=4'b0010 for 1 cycle.
//    Then cnt_clr for 1 cycle, count 1,2,3 on the following 3 cycles.
//    Then done_valid with done_id=1, count=3.
//  3 Round-robin: all four valid with len=1, done_ready=1 -> grant order 0,1,2,3,0.
//    Each grant is followed by exactly 1 cnt_en.
//  4 Zero length: len=0 on req 2 -> CLEAR then DONE, cnt_en never 1, done_id=2.
//  5 Hold/backpressure: len=5, hold=1 for cycles 2-4 of RUN -> count stalls and 5 cnt_en total.
//    Then done_ready=0 for 3 cycles -> done_valid held and no new req_ready.
//  6 Reset mid-run: rst=0 while count=2 of len=6 -> count=0 and busy=0 immediately.
//    No done_valid is issued; rr_ptr=0 afterwards.

Source files
------------

// File: rtl/counter_share_ctrl_pkg.sv
// counter_share_pkg: shared state encoding and limits for the counter share scheduler
package counter_share_pkg;
  typedef enum logic [1:0] {CS_IDLE, CS_CLEAR, CS_RUN, CS_DONE} cs_state_e;
  localparam int CS_MAX_NREQ = 16;
endpackage

// File: rtl/counter_share_ctrl_if.sv
// counter_share_ctrl_if: request, counter and completion signals of the shared counter
interface counter_share_ctrl_if #(
  parameter int NREQ = 4,
  parameter int WIDTH = 8,
  localparam int IDW = $clog2(NREQ)
);
  logic [NREQ-1:0]       req_valid;
  logic [NREQ*WIDTH-1:0] req_len;
  logic [NREQ-1:0]       req_ready;
  logic                  hold;
  logic                  cnt_clr;
  logic                  cnt_en;
  logic [WIDTH-1:0]      count;
  logic                  busy;
  logic [IDW-1:0]        owner;
  logic                  done_valid;
  logic [IDW-1:0]        done_id;
  logic                  done_ready;
  modport master (
    output req_valid, req_len, hold, done_ready,
    input  req_ready, cnt_clr, cnt_en, count, busy, owner, done_valid, done_id
  );
  modport slave (
    input  req_valid, req_len, hold, done_ready,
    output req_ready, cnt_clr, cnt_en, count, busy, owner, done_valid, done_id
  );
endinterface

// File: rtl/counter_share_ctrl_rr_pick.sv
// counter_share_rr_pick: first set request at or after ptr, wrapping modulo NREQ
module counter_share_rr_pick #(
  parameter int NREQ = 4,
  localparam int IDW = $clog2(NREQ)
) (
  input  logic [NREQ-1:0] req,
  input  logic [IDW-1:0]  ptr,
  output logic [NREQ-1:0] grant,
  output logic [IDW-1:0]  gid,
  output logic            any
);
  logic [IDW-1:0] idx;
  always_comb begin
    gid = '0;
    idx = '0;
    // scan downward so the candidate closest to ptr is written last
    for (int k = NREQ - 1; k >= 0; k--) begin
      idx = IDW'((int'(ptr) + k) % NREQ);
      gid = req[idx] ? idx : gid;
    end
    any = |req;
    grant = any ? (NREQ'(1) << gid) : '0;
  end
endmodule

// File: rtl/counter_share_ctrl.sv
// counter_share_ctrl: round-robin scheduler lending one up-counter to NREQ requesters
module counter_share_ctrl
  import counter_share_pkg::*;
#(
  parameter int NREQ = 4,
  parameter int WIDTH = 8,
  localparam int IDW = $clog2(NREQ)
) (
  input logic clk,
  input logic rst,
  counter_share_ctrl_if.slave bus
);
  cs_state_e        state, nstate;
  logic [WIDTH-1:0] count, count_inc, len_q;
  logic [IDW-1:0]   owner_q, rr_ptr, gid;
  logic [NREQ-1:0]  grant;
  logic             any;
  logic [WIDTH-1:0] lens [NREQ];
  for (genvar i = 0; i < NREQ; i++) begin : g_len
    assign lens[i] = bus.req_len[i*WIDTH +: WIDTH];
  end
  assign count_inc = count + 1'b1;
  counter_share_rr_pick #(.NREQ(NREQ)) u_pick (
    .req(bus.req_valid), .ptr(rr_ptr), .grant(grant), .gid(gid), .any(any)
  );
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= CS_IDLE;
      count <= '0;
      len_q <= '0;
      owner_q <= '0;
      rr_ptr <= '0;
    end else begin
      state <= nstate;
      if (state == CS_IDLE && any) begin
        len_q <= lens[gid];
        owner_q <= gid;
      end
      if (state == CS_CLEAR) count <= '0;
      if (state == CS_RUN && !bus.hold) count <= count_inc;
      if (state == CS_DONE && bus.done_ready)
        rr_ptr <= (owner_q == IDW'(NREQ - 1)) ? '0 : owner_q + 1'b1;
    end
  end
  always_comb begin
    nstate = state == CS_IDLE  ? (any ? CS_CLEAR : CS_IDLE) :
             state == CS_CLEAR ? (len_q == '0 ? CS_DONE : CS_RUN) :
             state == CS_RUN   ? ((!bus.hold && count_inc == len_q) ? CS_DONE : CS_RUN) :
                                 (bus.done_ready ? CS_IDLE : CS_DONE);
  end
  // grant is combinational from req_valid, so mask it while reset is held
  always_comb begin
    bus.req_ready  = (state == CS_IDLE && rst) ? grant : '0;
    bus.cnt_clr    = state == CS_CLEAR;
    bus.cnt_en     = state == CS_RUN && !bus.hold;
    bus.count      = count;
    bus.busy       = state != CS_IDLE;
    bus.owner      = owner_q;
    bus.done_valid = state == CS_DONE;
    bus.done_id    = owner_q;
  end
endmodule

// File: tb/tb_counter_share_ctrl.sv
// tb_counter_share_ctrl: directed checks of grant order, counting, hold, completion and reset
module tb_counter_share_ctrl;
  logic clk, rst;
  int n_chk, n_fail, en_cnt;
  logic [7:0] exp_cnt [8];
  logic       exp_en  [8];
  counter_share_ctrl_if #(.NREQ(4), .WIDTH(8)) bus ();
  counter_share_ctrl #(.NREQ(4), .WIDTH(8)) dut (.clk(clk), .rst(rst), .bus(bus));
  initial clk = 0;
  always #5 clk = ~clk;
  task automatic tick;
    @(posedge clk);
    #1;
  endtask
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask
  initial begin
    n_chk = 0;
    n_fail = 0;
    exp_cnt = '{8'd0, 8'd1, 8'd1, 8'd1, 8'd1, 8'd2, 8'd3, 8'd4};
    exp_en  = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1};
    rst = 0;
    bus.req_valid = 4'($urandom_range(1, 15));
    bus.req_len = 32'($urandom);
    bus.hold = 1'($urandom);
    bus.done_ready = 1'($urandom);
    #1;
    chk("rst_req_ready", 32'(bus.req_ready), 0);
    chk("rst_cnt_clr", 32'(bus.cnt_clr), 0);
    chk("rst_cnt_en", 32'(bus.cnt_en), 0);
    chk("rst_count", 32'(bus.count), 0);
    chk("rst_busy", 32'(bus.busy), 0);
    chk("rst_owner", 32'(bus.owner), 0);
    chk("rst_done_valid", 32'(bus.done_valid), 0);
    chk("rst_done_id", 32'(bus.done_id), 0);
    tick();
    chk("rst_held_busy", 32'(bus.busy), 0);
    bus.req_valid = 0; bus.req_len = 0; bus.hold = 0; bus.done_ready = 0;
    rst = 1;
    tick();
    chk("idle_busy", 32'(bus.busy), 0);
    chk("idle_ready", 32'(bus.req_ready), 0);
    // single run of length 3 on requester 1
    bus.req_valid = 4'b0010;
    bus.req_len[8 +: 8] = 8'd3;
    #1;
    chk("s_ready", 32'(bus.req_ready), 32'b0010);
    tick();
    bus.req_valid = 0;
    #1;
    chk("s_ready_drop", 32'(bus.req_ready), 0);
    chk("s_clr", 32'(bus.cnt_clr), 1);
    chk("s_busy", 32'(bus.busy), 1);
    chk("s_owner", 32'(bus.owner), 1);
    tick();
    chk("s_clr_end", 32'(bus.cnt_clr), 0);
    chk("s_en0", 32'(bus.cnt_en), 1);
    chk("s_cnt0", 32'(bus.count), 0);
    tick();
    chk("s_cnt1", 32'(bus.count), 1);
    tick();
    chk("s_cnt2", 32'(bus.count), 2);
    chk("s_no_done", 32'(bus.done_valid), 0);
    tick();
    chk("s_done", 32'(bus.done_valid), 1);
    chk("s_done_id", 32'(bus.done_id), 1);
    chk("s_cnt3", 32'(bus.count), 3);
    chk("s_en_off", 32'(bus.cnt_en), 0);
    tick();
    chk("s_done_hold", 32'(bus.done_valid), 1);
    bus.done_ready = 1;
    tick();
    bus.done_ready = 0;
    chk("s_idle", 32'(bus.busy), 0);
    chk("s_done_gone", 32'(bus.done_valid), 0);
    // round robin from a fresh pointer
    rst = 0;
    #1;
    rst = 1;
    bus.req_valid = 4'b1111;
    bus.req_len = {8'd1, 8'd1, 8'd1, 8'd1};
    bus.done_ready = 1;
    for (int g = 0; g < 5; g++) begin
      #1;
      chk("rr_ready", 32'(bus.req_ready), 32'(4'b0001 << (g % 4)));
      en_cnt = 0;
      for (int c = 0; c < 4; c++) begin
        en_cnt += int'(bus.cnt_en);
        if (c == 2) chk("rr_done_id", 32'(bus.done_id), 32'(g % 4));
        tick();
        if (c == 2) chk("rr_done", 32'(bus.done_valid), 1);
      end
      chk("rr_en_count", 32'(en_cnt), 1);
      if (g == 4) bus.req_valid = 0;
    end
    bus.done_ready = 0;
    // zero length: pointer now at 1, request 2 wins
    bus.req_valid = 4'b0100;
    bus.req_len[16 +: 8] = 8'd0;
    #1;
    chk("z_ready", 32'(bus.req_ready), 32'b0100);
    tick();
    bus.req_valid = 0;
    chk("z_clr", 32'(bus.cnt_clr), 1);
    chk("z_en_clr", 32'(bus.cnt_en), 0);
    tick();
    chk("z_done", 32'(bus.done_valid), 1);
    chk("z_done_id", 32'(bus.done_id), 2);
    chk("z_en_done", 32'(bus.cnt_en), 0);
    chk("z_cnt", 32'(bus.count), 0);
    bus.done_ready = 1;
    tick();
    bus.done_ready = 0;
    // hold during run, pointer now at 3, request 0 wins
    bus.req_valid = 4'b0001;
    bus.req_len[0 +: 8] = 8'd5;
    #1;
    chk("h_ready", 32'(bus.req_ready), 32'b0001);
    tick();
    bus.req_valid = 0;
    chk("h_clr", 32'(bus.cnt_clr), 1);
    tick();
    en_cnt = 0;
    for (int c = 0; c < 8; c++) begin
      bus.hold = (c >= 1 && c <= 3);
      #1;
      chk("h_cnt", 32'(bus.count), 32'(exp_cnt[c]));
      chk("h_en", 32'(bus.cnt_en), 32'(exp_en[c]));
      en_cnt += int'(bus.cnt_en);
      tick();
    end
    bus.hold = 0;
    chk("h_en_total", 32'(en_cnt), 5);
    bus.req_valid = 4'b0010;
    bus.req_len[8 +: 8] = 8'd6;
    for (int c = 0; c < 3; c++) begin
      #1;
      chk("h_done_held", 32'(bus.done_valid), 1);
      chk("h_no_ready", 32'(bus.req_ready), 0);
      chk("h_cnt_final", 32'(bus.count), 5);
      tick();
    end
    bus.done_ready = 1;
    tick();
    bus.done_ready = 0;
    chk("h_idle", 32'(bus.busy), 0);
    // reset in the middle of a length-6 run on requester 1
    chk("r_ready", 32'(bus.req_ready), 32'b0010);
    tick();
    bus.req_valid = 0;
    tick();
    tick();
    tick();
    chk("r_cnt2", 32'(bus.count), 2);
    #2;
    rst = 0;
    #1;
    chk("r_cnt", 32'(bus.count), 0);
    chk("r_busy", 32'(bus.busy), 0);
    chk("r_en", 32'(bus.cnt_en), 0);
    chk("r_owner", 32'(bus.owner), 0);
    #1;
    rst = 1;
    for (int c = 0; c < 8; c++) begin
      tick();
      chk("r_no_done", 32'(bus.done_valid), 0);
    end
    bus.req_valid = 4'b1111;
    #1;
    chk("r_ptr_zero", 32'(bus.req_ready), 32'b0001);
    bus.req_valid = 0;
    tick();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
